avg_channel_scheduler: RTL and testbench

//  Time-shares ONE first-order lowpass (time-weighted average) datapath between N sample channels.

---
 rtl/avg_channel_scheduler.sv | 135 +++++++++++++
 tb/tb_avg_channel_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : avg_channel_scheduler
// Purpose : one shared first-order lowpass datapath time-shared round-robin
//           across N_CH sample channels. Optional macro: AVG_ABS_EN (averages |x|).
// Revision: 1.0 - initial release
// ============================================================================
module avg_channel_scheduler #(
  parameter int N_CH       = 4,
  parameter int CHW        = 2,
  parameter int DK_DEFAULT = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      in_valid,
  input  logic [32*N_CH-1:0]   in_data,
  output logic [N_CH-1:0]      in_ready,
  input  logic                 cfg_we,
  input  logic                 cfg_clr,
  input  logic [CHW-1:0]       cfg_ch,
  input  logic [4:0]           cfg_dk,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_ch,
  output logic [9:0]           out_data,
  output logic                 busy
);

  localparam logic [CHW:0] N_CH_W = (CHW+1)'(N_CH);

  logic [CHW-1:0]     rr_ptr;
  logic               s1_vld;
  logic [CHW-1:0]     s1_ch;
  logic [31:0]        s1_in;
  logic signed [31:0] acc [N_CH];
  logic [4:0]         dk  [N_CH];

  logic               grant_found;
  logic [CHW-1:0]     grant_ch;
  logic [31:0]        grant_data;
  logic [CHW:0]       scan;
  logic [CHW-1:0]     next_ptr;

  // Scan from rr_ptr upward, wrapping at N_CH; the first requester wins.
  always_comb begin
    in_ready    = '0;
    grant_found = 1'b0;
    grant_ch    = '0;
    grant_data  = '0;
    scan        = '0;
    for (int i = 0; i < N_CH; i++) begin
      scan = {1'b0, rr_ptr} + (CHW+1)'(i);
      if (scan >= N_CH_W) scan = scan - N_CH_W;
      if (!grant_found && in_valid[scan[CHW-1:0]]) begin
        grant_found = 1'b1;
        grant_ch    = scan[CHW-1:0];
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (grant_found && grant_ch == CHW'(i)) begin
        in_ready[i] = 1'b1;
        grant_data  = in_data[32*i +: 32];
      end
    end
  end

  assign next_ptr = ({1'b0, grant_ch} + 1'b1 >= N_CH_W) ? '0 : grant_ch + 1'b1;

  logic signed [31:0] acc_cur;
  logic signed [31:0] x_val;
  logic signed [31:0] acc_new;
  logic [4:0]         k;

  always_comb begin
    acc_cur = acc[s1_ch];
    k       = dk[s1_ch];
`ifdef AVG_ABS_EN
    if (s1_in == 32'h8000_0000)
      x_val = 32'sh7FFF_FFFF;
    else if (s1_in[31])
      x_val = -$signed(s1_in);
    else
      x_val = $signed(s1_in);
`else
    x_val = $signed(s1_in);
`endif
    acc_new = acc_cur - (acc_cur >>> k) + (x_val >>> k);
  end

  // A clear on the channel being written overrides the update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        acc[i] <= '0;
        dk[i]  <= 5'(DK_DEFAULT);
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_clr && cfg_ch == CHW'(i))
          acc[i] <= '0;
        else if (s1_vld && s1_ch == CHW'(i))
          acc[i] <= acc_new;
        if (cfg_we && cfg_ch == CHW'(i))
          dk[i] <= cfg_dk;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      s1_vld    <= 1'b0;
      s1_ch     <= '0;
      s1_in     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      s1_vld <= grant_found;
      if (grant_found) begin
        rr_ptr <= next_ptr;
        s1_ch  <= grant_ch;
        s1_in  <= grant_data;
      end
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_ch   <= s1_ch;
        out_data <= acc_new[30:21];
      end
    end
  end

  assign busy = (|in_valid) | s1_vld | out_valid;

endmodule
`default_nettype wire

// File: tb/tb_avg_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_avg_channel_scheduler
// Purpose : directed + random bench for avg_channel_scheduler against a
//           cycle-level reference model. Honours AVG_ABS_EN like the design.
// Revision: 1.0 - initial release
// ============================================================================
module tb_avg_channel_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  in_valid;
  logic [32*N-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          cfg_we, cfg_clr;
  logic [1:0]    cfg_ch;
  logic [4:0]    cfg_dk;
  logic          out_valid;
  logic [1:0]    out_ch;
  logic [9:0]    out_data;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  avg_channel_scheduler #(.N_CH(N), .CHW(2), .DK_DEFAULT(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_ch(cfg_ch),
    .cfg_dk(cfg_dk), .out_valid(out_valid), .out_ch(out_ch),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic signed [31:0] m_acc [N];
  int                 m_dk  [N];
  int                 m_rr;
  logic               m_s1v;
  int                 m_s1ch;
  logic [31:0]        m_s1in;
  logic               m_ov;
  logic [1:0]         m_och;
  logic [9:0]         m_od;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_acc[i] = '0;
      m_dk[i]  = 5;
    end
    m_rr = 0; m_s1v = 1'b0; m_s1ch = 0; m_s1in = '0;
    m_ov = 1'b0; m_och = '0; m_od = '0;
  endtask

  function automatic int model_grant();
    int idx;
    for (int i = 0; i < N; i++) begin
      idx = (m_rr + i) % N;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic signed [31:0] sample_value(input logic [31:0] v);
`ifdef AVG_ABS_EN
    if (v == 32'h8000_0000) return 32'sh7FFF_FFFF;
    if (v[31]) return -$signed(v);
`endif
    return $signed(v);
  endfunction

  task automatic model_edge(input int gi);
    logic signed [31:0] a, x, nw;
    int k;
    if (m_s1v) begin
      a  = m_acc[m_s1ch];
      k  = m_dk[m_s1ch];
      x  = sample_value(m_s1in);
      nw = a - (a >>> k) + (x >>> k);
      m_acc[m_s1ch] = nw;
      m_od  = nw[30:21];
      m_och = 2'(m_s1ch);
    end
    m_ov = m_s1v;
    if (cfg_clr) m_acc[cfg_ch] = '0;
    if (cfg_we)  m_dk[cfg_ch]  = int'(cfg_dk);
    if (gi >= 0) begin
      m_s1v  = 1'b1;
      m_s1ch = gi;
      m_s1in = in_data[32*gi +: 32];
      m_rr   = (gi + 1) % N;
    end else begin
      m_s1v = 1'b0;
    end
  endtask

  // One clock: check grant before the edge, outputs after it.
  task automatic step();
    int gi;
    logic [3:0] g;
    gi = model_grant();
    g  = (gi < 0) ? 4'b0000 : 4'(1 << gi);
    #1;
    chk("in_ready", 32'(in_ready), 32'(g));
    chk("busy", 32'(busy), 32'((|in_valid) | m_s1v | m_ov));
    @(posedge clk);
    model_edge(gi);
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_ch", 32'(out_ch), 32'(m_och));
    chk("out_data", 32'(out_data), 32'(m_od));
  endtask

  task automatic idle_cfg();
    cfg_we = 1'b0; cfg_clr = 1'b0; cfg_ch = '0; cfg_dk = '0;
  endtask

  logic [31:0] d4;

  initial begin
    reset = 1'b1; in_valid = '0; in_data = '0;
    idle_cfg();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // ch0 dk=2, constant 0x4000_0000 -> 128, 224, 296, ... 512
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_dk = 5'd2;
    step();
    idle_cfg();
    in_valid = 4'b0001; in_data[31:0] = 32'h4000_0000;
    step(); step();
    chk("t1_first", 32'(out_data), 32'd128);
    chk("t1_ch", 32'(out_ch), 32'd0);
    step(); chk("t1_second", 32'(out_data), 32'd224);
    step(); chk("t1_third", 32'(out_data), 32'd296);
    repeat (100) step();
    chk("t1_converged", 32'(out_data), 32'd512);

    // All channels requesting
    in_valid = 4'b1111;
    for (int i = 0; i < N; i++) in_data[32*i +: 32] = $urandom;
    repeat (10) step();

    // Sparse requesters ch1 and ch3
    in_valid = 4'b1010;
    repeat (6) step();
    in_valid = '0;
    repeat (2) step();

    // dk change colliding with ch0 stage-1 op
    in_valid = 4'b0001; in_data[31:0] = $urandom;
    step();
    in_valid = '0; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_dk = 5'd0;
    step();
    idle_cfg();
    d4 = $urandom;
    in_valid = 4'b0001; in_data[31:0] = d4;
    step();
    in_valid = '0;
    step();
    chk("t4_dk0_passthru", 32'(out_data), 32'(d4[30:21]));

    // clear colliding with ch2 write
    cfg_we = 1'b1; cfg_clr = 1'b1; cfg_ch = 2'd2; cfg_dk = 5'd2;
    step();
    idle_cfg();
    in_valid = 4'b0100; in_data[95:64] = 32'h4000_0000;
    step();
    in_valid = '0; cfg_clr = 1'b1; cfg_ch = 2'd2;
    step();
    chk("t5_clr_out", 32'(out_data), 32'd128);
    idle_cfg();
    in_valid = 4'b0100;
    step();
    in_valid = '0;
    step();
    chk("t5_after_clr", 32'(out_data), 32'd128);

    // negative input on ch3, dk=2
    cfg_we = 1'b1; cfg_clr = 1'b1; cfg_ch = 2'd3; cfg_dk = 5'd2;
    step();
    idle_cfg();
    in_valid = 4'b1000; in_data[127:96] = 32'hC000_0000;
    step();
    in_valid = '0;
    step();
`ifdef AVG_ABS_EN
    chk("t6_abs", 32'(out_data), 32'd128);
`else
    chk("t6_signed", 32'(out_data), 32'h380);
`endif

    // Randomised traffic and configuration
    for (int n = 0; n < 400; n++) begin
      in_valid = 4'($urandom);
      for (int i = 0; i < N; i++) in_data[32*i +: 32] = $urandom;
      cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_clr = ($urandom_range(0, 9) == 0);
      cfg_ch  = 2'($urandom);
      cfg_dk  = 5'($urandom_range(0, 8));
      step();
    end
    idle_cfg();

    // Asynchronous reset in the middle of traffic
    in_valid = 4'b1111;
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_ch", 32'(out_ch), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (6) step();
    in_valid = '0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
